// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin arbiter in front of a shared N-to-M immediate extender,
// with a single-entry valid/ready output register. Define IMM_EXT_ZEXT_EN to honour i_zextk.
module imm_ext_arbiter #(
   parameter int N = 16,
   parameter int M = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_req0,
   input  logic [N-1:0] i_data0,
   input  logic         i_zext0,
   output logic         o_gnt0,
   input  logic         i_req1,
   input  logic [N-1:0] i_data1,
   input  logic         i_zext1,
   output logic         o_gnt1,
   output logic         o_valid,
   output logic [M-1:0] o_data,
   output logic         o_src,
   input  logic         i_ready
);

   generate
      if (M <= N) begin : g_bad_width
         $error("imm_ext_arbiter: M must be greater than N");
      end
   endgenerate

   logic         valid_q, valid_d;
   logic [M-1:0] data_q, data_d;
   logic         src_q, src_d;
   logic         prio_q, prio_d;

   logic         free;
   logic         gnt0, gnt1;
   logic [N-1:0] sel_data;
   logic         sel_zext;
   logic         fill_bit;
   logic [M-1:0] ext_data;

   // A slot is free when empty or when the consumer drains it this very cycle.
   assign free = !valid_q || i_ready;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!i_rst && free) begin
         if (i_req0 && i_req1) begin
            gnt0 = !prio_q;
            gnt1 = prio_q;
         end else begin
            gnt0 = i_req0;
            gnt1 = i_req1;
         end
      end
   end

   assign o_gnt0 = gnt0;
   assign o_gnt1 = gnt1;

   assign sel_data = gnt1 ? i_data1 : i_data0;
   assign sel_zext = gnt1 ? i_zext1 : i_zext0;

`ifdef IMM_EXT_ZEXT_EN
   assign fill_bit = sel_zext ? 1'b0 : sel_data[N-1];
`else
   logic zext_unused;
   assign zext_unused = sel_zext;
   assign fill_bit    = sel_data[N-1];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < M; gi = gi + 1) begin : g_ext
         if (gi < N) begin : g_low
            assign ext_data[gi] = sel_data[gi];
         end else begin : g_high
            assign ext_data[gi] = fill_bit;
         end
      end
   endgenerate

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      src_d   = src_q;
      prio_d  = prio_q;
      if (gnt0 || gnt1) begin
         valid_d = 1'b1;
         data_d  = ext_data;
         src_d   = gnt1;
         prio_d  = !gnt1;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
         prio_q  <= prio_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_src   = src_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed self-checking bench for imm_ext_arbiter (N=16, M=32).
module tb_imm_ext_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, req1, zext0, zext1, ready;
   logic [15:0] data0, data1;
   logic        gnt0, gnt1, valid, src;
   logic [31:0] odata;

   int pass_cnt = 0;
   int total_cnt = 0;
   int fail_cnt = 0;

   imm_ext_arbiter #(.N(16), .M(32)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_req0  (req0),
      .i_data0 (data0),
      .i_zext0 (zext0),
      .o_gnt0  (gnt0),
      .i_req1  (req1),
      .i_data1 (data1),
      .i_zext1 (zext1),
      .o_gnt1  (gnt1),
      .o_valid (valid),
      .o_data  (odata),
      .o_src   (src),
      .i_ready (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [31:0] zext_exp;

   initial begin
`ifdef IMM_EXT_ZEXT_EN
      zext_exp = 32'h0000_8000;
`else
      zext_exp = 32'hFFFF_8000;
`endif
      rst = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 16'h1234; data1 = 16'h0000;
      zext0 = 1'b0; zext1 = 1'b0; ready = 1'b1;

      // reset with requests pending
      settle();
      check("rst_gnt0", {31'd0, gnt0}, 32'd0);
      check("rst_gnt1", {31'd0, gnt1}, 32'd0);
      tick();
      tick();
      check("rst_gnt0_b", {31'd0, gnt0}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_data", odata, 32'h0000_0000);
      check("rst_src", {31'd0, src}, 32'd0);

      // release: requester 0 wins first
      rst = 1'b0; req1 = 1'b0;
      settle();
      check("rel_gnt0", {31'd0, gnt0}, 32'd1);
      tick();
      check("rel_valid", {31'd0, valid}, 32'd1);
      check("rel_data", odata, 32'h0000_1234);
      check("rel_src", {31'd0, src}, 32'd0);

      // single request, negative operand
      data0 = 16'h8001;
      settle();
      check("single_gnt0", {31'd0, gnt0}, 32'd1);
      tick();
      req0 = 1'b0;
      check("single_data", odata, 32'hFFFF_8001);
      check("single_src", {31'd0, src}, 32'd0);

      // backpressure: frozen register, no grant
      ready = 1'b0; req1 = 1'b1; data1 = 16'h5555;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("bp_gnt1", {31'd0, gnt1}, 32'd0);
         check("bp_valid", {31'd0, valid}, 32'd1);
         check("bp_data", odata, 32'hFFFF_8001);
         tick();
      end
      ready = 1'b1;
      settle();
      check("bp_release_gnt1", {31'd0, gnt1}, 32'd1);
      tick();
      req1 = 1'b0;
      check("bp_refill_valid", {31'd0, valid}, 32'd1);
      check("bp_refill_data", odata, 32'h0000_5555);
      check("bp_refill_src", {31'd0, src}, 32'd1);

      // drain with no request
      settle();
      tick();
      check("drain_valid", {31'd0, valid}, 32'd0);

      // contention: prio is 0 after the last grant to 1
      req0 = 1'b1; req1 = 1'b1; data0 = 16'h7FFF; data1 = 16'h8000;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("cont_gnt0", {31'd0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check("cont_gnt1", {31'd0, gnt1}, (i % 2 == 1) ? 32'd1 : 32'd0);
         tick();
         check("cont_data", odata, (i % 2 == 0) ? 32'h0000_7FFF : 32'hFFFF_8000);
         check("cont_src", {31'd0, src}, (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      req0 = 1'b0; req1 = 1'b0;

      // zero-extension request
      req1 = 1'b1; data1 = 16'h8000; zext1 = 1'b1;
      settle();
      check("zext_gnt1", {31'd0, gnt1}, 32'd1);
      tick();
      req1 = 1'b0; zext1 = 1'b0;
      check("zext_data", odata, zext_exp);
      check("zext_src", {31'd0, src}, 32'd1);

      // set up FULL with prio=1, then reset mid-operation
      req0 = 1'b1; data0 = 16'h0042;
      settle();
      check("pre_rst_gnt0", {31'd0, gnt0}, 32'd1);
      tick();
      check("pre_rst_data", odata, 32'h0000_0042);
      req0 = 1'b0; ready = 1'b0; rst = 1'b1;
      tick();
      check("mid_rst_valid", {31'd0, valid}, 32'd0);
      check("mid_rst_data", odata, 32'h0000_0000);
      rst = 1'b0; ready = 1'b1;
      req0 = 1'b1; req1 = 1'b1; data0 = 16'h0001; data1 = 16'hFFFF;
      settle();
      check("post_rst_gnt0", {31'd0, gnt0}, 32'd1);
      check("post_rst_gnt1", {31'd0, gnt1}, 32'd0);
      tick();
      check("post_rst_data", odata, 32'h0000_0001);
      check("post_rst_src", {31'd0, src}, 32'd0);
      check("post_rst_next_gnt1", {31'd0, gnt1}, 32'd1);
      tick();
      req0 = 1'b0; req1 = 1'b0;
      check("post_rst_data1", odata, 32'hFFFF_FFFF);
      check("post_rst_src1", {31'd0, src}, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
